axi4_lite_slave_regs: RTL and testbench
=======================================

# axi4_lite_slave_regs

AXI4-Lite slave register bank: the downstream target of `axi4_lite_master`, consuming its write and read transactions. It holds `NUM_REGS` 32-bit registers with byte-strobe writes and independent read/write channels. Out-of-range accesses return SLVERR. All registers are exported as a flat vector for use by surrounding logic.

## Interface
- `ADDR_W`, 32, AXI address width
- `DATA_W`, 32, data width (fixed 32; `STRB_W = DATA_W/8`)
- `NUM_REGS`, 16, register count, power of two, ≥2
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `AWADDR` in ADDR_W, `AWVALID` in 1, `AWREADY` out 1: write address channel
- `WDATA` in DATA_W, `WSTRB` in STRB_W, `WVALID` in 1, `WREADY` out 1: write data channel
- `BRESP` out 2, `BVALID` out 1, `BREADY` in 1: write response channel
- `ARADDR` in ADDR_W, `ARVALID` in 1, `ARREADY` out 1: read address channel
- `RDATA` out DATA_W, `RRESP` out 2, `RVALID` out 1, `RREADY` in 1: read data channel
- `regs_o` out NUM_REGS*DATA_W: current register contents; reg i at bits `[i*32 +: 32]`
- `wr_pulse_o` out NUM_REGS: one-cycle pulse on the cycle after a register is written

## Operation
- **Decode:** `idx = addr[2 +: $clog2(NUM_REGS)]`; `addr[1:0]` ignored. In range iff `addr < NUM_REGS*4`, else SLVERR (2'b10); OKAY is 2'b00.
- **Write FSM, state W_IDLE:**
  - `AWREADY = !aw_held`, `WREADY = !w_held`.
  - Each handshake latches its payload and sets its held flag. AW and W may arrive in either order or in the same cycle.
  - When both are present (held, or handshaking this cycle), commit at that edge and go to W_RESP.
  - In range: for each byte b with `WSTRB[b]=1`, update `reg[idx][8b+:8]`. Out of range: no state change.
- **Write FSM, state W_RESP:**
  - `BVALID=1`, `AWREADY=WREADY=0`, `BRESP` held stable.
  - On `BREADY`, clear held flags and return to W_IDLE.
- **Read FSM, state R_IDLE:** `ARREADY=1`. On handshake, register `RDATA` (reg value, or 0 if out of range) and `RRESP`, then go to R_DATA.
- **Read FSM, state R_DATA:** `RVALID=1`, `ARREADY=0`, `RDATA`/`RRESP` stable until `RREADY`, then return to R_IDLE.
- **Independence:** read and write FSMs run concurrently with no cross-blocking.
- **Read/write collision:** if an AR handshake and a write commit hit the same register on the same edge, the read returns the pre-write value.
- **`WSTRB = 0`:** write completes with OKAY; register unchanged; `wr_pulse_o` still pulses.
- **Reset:**
  - All registers 0, both FSMs idle, held flags cleared.
  - `BVALID=RVALID=0`, `RDATA=0`, `BRESP=RRESP=0`, `wr_pulse_o=0`.
  - `AWREADY=WREADY=ARREADY=1` from the first cycle after reset.
  - Reset mid-transaction discards it; no response is issued.

## Timing
- **Write:** last of AW/W handshakes at edge N; register and `regs_o` updated after N; `BVALID=1` and `wr_pulse_o[idx]=1` in cycle N+1.
- **Read:** AR handshake at edge N; `RVALID=1` with data in cycle N+1.
- **Throughput:**
  - Write: one transaction per 2 cycles with `BREADY` tied high.
  - Read: one transaction per 2 cycles with `RREADY` tied high.
- **Output stability:** no combinational path from any input to any `*READY`/`*VALID`; all outputs are registered or decoded from state/held flags.
- **Backpressure:** `BVALID`/`RVALID` never drop without the matching ready.

## Structure
- **Shared package `axi4_lite_pkg`:**
  - `axi_resp_t` enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Write FSM state enum: W_IDLE, W_RESP.
  - Read FSM state enum: R_IDLE, R_DATA.
  - Constant `AXIL_DATA_W = 32`.
- **Sub-module `axi4_lite_reg_bank`:**
  - Storage array with strobe write port, combinational read port and flat `regs_o` output.
  - Instantiated once.
  - Channel FSMs stay in the top module.

## Test plan
- **Reset values:** assert `rst` for 2 cycles → all outputs at reset values, `regs_o == 0`, all three `*READY` high one cycle after release.
- **Simultaneous AW/W write:** AW+W same cycle, addr 0x08, data 0xDEADBEEF, strb 0xF → `BVALID` next cycle with `BRESP=0`, `reg[2]=0xDEADBEEF`, `wr_pulse_o=16'h0004` for one cycle.
- **W before AW, partial strobe:** W first (data 0x11223344, strb 0x5), AW three cycles later to 0x08 → `reg[2]=0xDE22BE44`; `WREADY` low while waiting for AW.
- **Read backpressure:** read 0x08 with `RREADY` low for 4 cycles → `RVALID`/`RDATA=0xDE22BE44` stable throughout, `ARREADY=0` until `RREADY`.
- **Out-of-range access:** write 0x40, then read 0x40 (NUM_REGS=16) → `BRESP=2'b10`, no register changes, `RDATA=0`, `RRESP=2'b10`.
- **Collision, then reset:** AR and write-commit to reg 5 on the same edge (old value 0x0, new 0xA5A5A5A5) → read returns 0x0, subsequent read returns 0xA5A5A5A5. Then assert `rst` while `BVALID` is pending → `BVALID=0` and all registers 0 next cycle.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions for the slave register bank.
// Provides the response code enum, the write/read channel FSM state
// enums and the fixed AXI4-Lite data width.
package axi4_lite_pkg;

    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi4_lite_slave_regs_if.sv
// AXI4-Lite bus bundle (five channels) between a master and a slave.
// Ports: AW (AWADDR/AWVALID/AWREADY), W (WDATA/WSTRB/WVALID/WREADY),
// B (BRESP/BVALID/BREADY), AR (ARADDR/ARVALID/ARREADY),
// R (RDATA/RRESP/RVALID/RREADY). Modports: master, slave.
interface axi4_lite_slave_regs_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

endinterface

// File: rtl/axi4_lite_reg_bank.sv
// Register storage for the AXI4-Lite slave.
// Ports: clk/rst (sync, active high), we/widx/wdata/wstrb byte-strobe
// write port, ridx/rdata combinational read port, regs_o flat contents
// (reg i at [i*32 +: 32]).
module axi4_lite_reg_bank
    import axi4_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we,
    input  logic [$clog2(NUM_REGS)-1:0]     widx,
    input  logic [AXIL_DATA_W-1:0]          wdata,
    input  logic [AXIL_STRB_W-1:0]          wstrb,
    input  logic [$clog2(NUM_REGS)-1:0]     ridx,
    output logic [AXIL_DATA_W-1:0]          rdata,
    output logic [NUM_REGS*AXIL_DATA_W-1:0] regs_o
);

    logic [AXIL_DATA_W-1:0] regs_q [NUM_REGS];
    logic [AXIL_DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            for (int unsigned b = 0; b < AXIL_STRB_W; b++) begin
                if (wstrb[b]) begin
                    regs_d[widx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port sees the pre-edge value, so a same-edge write is not visible.
    assign rdata = regs_q[ridx];

    always_comb begin
        regs_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_o[i*AXIL_DATA_W +: AXIL_DATA_W] = regs_q[i];
        end
    end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit byte-strobed registers.
// Ports: clk/rst (sync, active high), s (AXI4-Lite slave modport),
// regs_o (flat register contents), wr_pulse_o (one-cycle pulse per
// register on the cycle after it is written). Out-of-range -> SLVERR.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    axi4_lite_slave_regs_if.slave       s,
    output logic [NUM_REGS*DATA_W-1:0]  regs_o,
    output logic [NUM_REGS-1:0]         wr_pulse_o
);

    localparam int unsigned     IDX_W      = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_LIMIT;
    endfunction

    // ---------------- write channel ----------------
    w_state_t               w_state_q, w_state_d;
    logic                   aw_held_q, aw_held_d;
    logic                   w_held_q, w_held_d;
    logic [ADDR_W-1:0]      awaddr_q, awaddr_d;
    logic [AXIL_DATA_W-1:0] wdata_q, wdata_d;
    logic [AXIL_STRB_W-1:0] wstrb_q, wstrb_d;
    axi_resp_t              bresp_q, bresp_d;
    logic [NUM_REGS-1:0]    wr_pulse_q, wr_pulse_d;

    logic                   aw_hs, w_hs, commit, wr_ok;
    logic [ADDR_W-1:0]      wr_addr;
    logic [AXIL_DATA_W-1:0] wr_data;
    logic [AXIL_STRB_W-1:0] wr_strb;
    logic [IDX_W-1:0]       wr_idx;

    assign s.AWREADY = (w_state_q == W_IDLE) && !aw_held_q;
    assign s.WREADY  = (w_state_q == W_IDLE) && !w_held_q;
    assign s.BVALID  = (w_state_q == W_RESP);
    assign s.BRESP   = bresp_q;
    assign wr_pulse_o = wr_pulse_q;

    always_comb begin
        aw_hs   = s.AWVALID && s.AWREADY;
        w_hs    = s.WVALID && s.WREADY;
        // A handshake this cycle bypasses the holding register so the
        // commit can happen on the same edge as the later of AW/W.
        wr_addr = aw_hs ? s.AWADDR : awaddr_q;
        wr_data = w_hs ? s.WDATA : wdata_q;
        wr_strb = w_hs ? s.WSTRB : wstrb_q;
        wr_ok   = in_range(wr_addr);
        wr_idx  = wr_addr[2 +: IDX_W];
        commit  = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s.AWADDR;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s.WDATA;
                    wstrb_d  = s.WSTRB;
                end
                if (commit) begin
                    w_state_d = W_RESP;
                    bresp_d   = wr_ok ? OKAY : SLVERR;
                    if (wr_ok) begin
                        wr_pulse_d[wr_idx] = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (s.BREADY) begin
                    w_state_d = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------- read channel ----------------
    r_state_t               r_state_q, r_state_d;
    logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;
    axi_resp_t              rresp_q, rresp_d;
    logic [AXIL_DATA_W-1:0] bank_rdata;
    logic [IDX_W-1:0]       rd_idx;
    logic                   rd_ok;

    assign s.ARREADY = (r_state_q == R_IDLE);
    assign s.RVALID  = (r_state_q == R_DATA);
    assign s.RDATA   = rdata_q;
    assign s.RRESP   = rresp_q;
    assign rd_idx    = s.ARADDR[2 +: IDX_W];
    assign rd_ok     = in_range(s.ARADDR);

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (s.ARVALID) begin
                    r_state_d = R_DATA;
                    rdata_d   = rd_ok ? bank_rdata : '0;
                    rresp_d   = rd_ok ? OKAY : SLVERR;
                end
            end
            R_DATA: begin
                if (s.RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= OKAY;
            wr_pulse_q <= '0;
            r_state_q  <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            r_state_q  <= r_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    axi4_lite_reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (commit && wr_ok),
        .widx   (wr_idx),
        .wdata  (wr_data),
        .wstrb  (wr_strb),
        .ridx   (rd_idx),
        .rdata  (bank_rdata),
        .regs_o (regs_o)
    );

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: a table of single
// write/read transactions with hand-computed results, followed by
// hand-written multi-cycle sequences (reset, W-before-AW, read
// backpressure, read/write collision, reset during a pending response).
module tb_axi4_lite_slave_regs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_lite_slave_regs_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    logic [511:0] regs_o;
    logic [15:0]  wr_pulse_o;

    axi4_lite_slave_regs #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .NUM_REGS (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (bus),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [15:0] exp_pulse;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic check_regs(input string tag, input logic [511:0] exp);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_reg%0d", tag, i), 64'(regs_o[i*32 +: 32]), 64'(exp[i*32 +: 32]));
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                             output logic [1:0] resp, output logic [15:0] pulse);
        int n;
        @(negedge clk);
        bus.AWADDR  = a;
        bus.AWVALID = 1'b1;
        bus.WDATA   = d;
        bus.WSTRB   = st;
        bus.WVALID  = 1'b1;
        bus.BREADY  = 1'b0;
        n = 0;
        while (!(bus.AWREADY && bus.WREADY) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout("wr_accept");
        @(negedge clk);
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        n = 0;
        while (!bus.BVALID && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout("wr_bvalid");
        resp  = bus.BRESP;
        pulse = wr_pulse_o;
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.ARADDR  = a;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b0;
        n = 0;
        while (!bus.ARREADY && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout("rd_accept");
        @(negedge clk);
        bus.ARVALID = 1'b0;
        n = 0;
        while (!bus.RVALID && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout("rd_rvalid");
        d    = bus.RDATA;
        resp = bus.RRESP;
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   resp;
        logic [15:0]  pulse;
        logic [31:0]  rd;
        logic [511:0] exp_regs;

        bus.AWADDR = '0; bus.AWVALID = 1'b0;
        bus.WDATA  = '0; bus.WSTRB   = '0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;

        //            wr    addr          data          strb  resp   rdata         pulse
        vecs.push_back('{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0,        16'h0004});
        vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 16'h0});
        vecs.push_back('{1'b1, 32'h0000_000C, 32'h1234_5678, 4'h3, 2'b00, 32'h0,        16'h0008});
        vecs.push_back('{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'h0000_5678, 16'h0});
        vecs.push_back('{1'b1, 32'h0000_000D, 32'h99AA_BBCC, 4'h8, 2'b00, 32'h0,        16'h0008});
        vecs.push_back('{1'b0, 32'h0000_000F, 32'h0,         4'h0, 2'b00, 32'h9900_5678, 16'h0});
        vecs.push_back('{1'b1, 32'h0000_003C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0,        16'h8000});
        vecs.push_back('{1'b0, 32'h0000_003C, 32'h0,         4'h0, 2'b00, 32'hFFFF_FFFF, 16'h0});
        vecs.push_back('{1'b1, 32'h0000_0004, 32'hAAAA_AAAA, 4'h0, 2'b00, 32'h0,        16'h0002});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'h0,        16'h0});
        vecs.push_back('{1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 2'b10, 32'h0,        16'h0});
        vecs.push_back('{1'b0, 32'h0000_0040, 32'h0,         4'h0, 2'b10, 32'h0,        16'h0});
        vecs.push_back('{1'b1, 32'h0000_007C, 32'h5555_5555, 4'hF, 2'b10, 32'h0,        16'h0});
        vecs.push_back('{1'b0, 32'h0000_003C, 32'h0,         4'h0, 2'b00, 32'hFFFF_FFFF, 16'h0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h0,        16'h0});

        // ---- reset values ----
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_bvalid",  64'(bus.BVALID),  64'd0);
        check("rst_rvalid",  64'(bus.RVALID),  64'd0);
        check("rst_rdata",   64'(bus.RDATA),   64'd0);
        check("rst_bresp",   64'(bus.BRESP),   64'd0);
        check("rst_rresp",   64'(bus.RRESP),   64'd0);
        check("rst_pulse",   64'(wr_pulse_o),  64'd0);
        check("rst_readies", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'b111);
        check_regs("rst", '0);

        // ---- table-driven single transactions ----
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse);
                check($sformatf("v%0d_bresp", i), 64'(resp), 64'(vecs[i].exp_resp));
                check($sformatf("v%0d_pulse", i), 64'(pulse), 64'(vecs[i].exp_pulse));
                check($sformatf("v%0d_pulse_clear", i), 64'({bus.BVALID, wr_pulse_o}), 64'd0);
            end else begin
                axi_read(vecs[i].addr, rd, resp);
                check($sformatf("v%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
                check($sformatf("v%0d_rresp", i), 64'(resp), 64'(vecs[i].exp_resp));
                check($sformatf("v%0d_rvalid_clear", i), 64'(bus.RVALID), 64'd0);
            end
        end
        exp_regs = '0;
        exp_regs[2*32 +: 32]  = 32'hDEAD_BEEF;
        exp_regs[3*32 +: 32]  = 32'h9900_5678;
        exp_regs[15*32 +: 32] = 32'hFFFF_FFFF;
        check_regs("table", exp_regs);

        // ---- W before AW, partial strobe ----
        @(negedge clk);
        bus.WDATA = 32'h1122_3344; bus.WSTRB = 4'h5; bus.WVALID = 1'b1;
        @(negedge clk);
        bus.WVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("wfirst_wready_c%0d", c), 64'({bus.WREADY, bus.AWREADY, bus.BVALID}), 64'b010);
            if (c < 2) @(negedge clk);
        end
        bus.AWADDR = 32'h08; bus.AWVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0;
        check("wfirst_bvalid", 64'(bus.BVALID), 64'd1);
        check("wfirst_bresp",  64'(bus.BRESP),  64'd0);
        check("wfirst_pulse",  64'(wr_pulse_o), 64'h0004);
        check("wfirst_reg2",   64'(regs_o[2*32 +: 32]), 64'hDE22_BE44);
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        check("wfirst_bdone", 64'({bus.BVALID, wr_pulse_o}), 64'd0);

        // ---- read backpressure ----
        bus.ARADDR = 32'h08; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("bp_rvalid_c%0d", c), 64'({bus.RVALID, bus.ARREADY}), 64'b10);
            check($sformatf("bp_rdata_c%0d", c),  64'(bus.RDATA), 64'hDE22_BE44);
            @(negedge clk);
        end
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
        check("bp_release", 64'({bus.RVALID, bus.ARREADY}), 64'b01);

        // ---- read/write collision on reg 5 ----
        bus.AWADDR = 32'h14; bus.AWVALID = 1'b1;
        bus.WDATA  = 32'hA5A5_A5A5; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        bus.ARADDR = 32'h14; bus.ARVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        check("coll_valids", 64'({bus.BVALID, bus.RVALID}), 64'b11);
        check("coll_rdata",  64'(bus.RDATA), 64'h0);
        check("coll_reg5",   64'(regs_o[5*32 +: 32]), 64'hA5A5_A5A5);
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        check("coll_done", 64'({bus.BVALID, bus.RVALID}), 64'b00);
        axi_read(32'h14, rd, resp);
        check("coll_reread", 64'(rd), 64'hA5A5_A5A5);

        // ---- reset while BVALID pending ----
        @(negedge clk);
        bus.AWADDR = 32'h20; bus.AWVALID = 1'b1;
        bus.WDATA  = 32'h5A5A_5A5A; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        check("prerst_bvalid", 64'(bus.BVALID), 64'd1);
        check("prerst_reg8",   64'(regs_o[8*32 +: 32]), 64'h5A5A_5A5A);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outs", 64'({bus.BVALID, bus.RVALID, wr_pulse_o}), 64'd0);
        check_regs("midrst", '0);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_readies", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID}), 64'b1110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
